// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default VGA timing sets and sync polarity encoding
package vga_timing_pkg;
  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam int CNT_W_DEFAULT    = 10;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (position, terminal flag, registered sync, next-position active flag)
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = VGA640_H_ACTIVE,
  parameter int FP     = VGA640_H_FP,
  parameter int SYNC   = VGA640_H_SYNC,
  parameter int BP     = VGA640_H_BP,
  parameter bit POL    = POL_LOW,
  parameter int W      = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         sync,
  output logic         active
);
  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  logic [W-1:0] count_d, count_q;
  logic         sync_d, sync_q;
  assign wrap  = count_q == LAST;
  assign count = count_q;
  assign sync  = sync_q;
  // Next position; reset parks on the last position so the first tick lands on 0
  always_comb begin
    count_d = rst ? LAST : !en ? count_q : wrap ? '0 : count_q + 1'b1;
    sync_d  = (count_d >= SYNC_LO && count_d <= SYNC_HI) ? POL : !POL;
    active  = count_d < ACT_END;
  end
  // Position and sync register together so they never skew
  always_ff @(posedge clk) begin
    count_q <= count_d;
    sync_q  <= sync_d;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing with pixel enable, programmable polarity and line/frame strobes
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit H_POL    = POL_LOW,
  parameter bit V_POL    = POL_LOW,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Pix_En,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_Display_On,
  output logic [CNT_W-1:0] o_Col_Count,
  output logic [CNT_W-1:0] o_Row_Count,
  output logic             o_Line_Start,
  output logic             o_Frame_Start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if ((2**CNT_W) < H_TOTAL || (2**CNT_W) < V_TOTAL || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
    $error("vga_timing_gen: counter too narrow or zero porch/sync width");
  end
  logic h_wrap, v_wrap, h_act, v_act;
  logic display_d, display_q, line_d, line_q, frame_d, frame_q;
  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .W(CNT_W)
  ) u_h (
    .clk(i_Clk), .rst(i_Rst), .en(i_Pix_En),
    .count(o_Col_Count), .wrap(h_wrap), .sync(o_HSync), .active(h_act)
  );
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .W(CNT_W)
  ) u_v (
    .clk(i_Clk), .rst(i_Rst), .en(i_Pix_En & h_wrap),
    .count(o_Row_Count), .wrap(v_wrap), .sync(o_VSync), .active(v_act)
  );
  // Display and strobes follow the next position so they align with the counts
  always_comb begin
    display_d = h_act & v_act;
    line_d    = !i_Rst & i_Pix_En & h_wrap;
    frame_d   = line_d & v_wrap;
  end
  // Registered display flag and single-clock strobes
  always_ff @(posedge i_Clk) begin
    display_q <= display_d;
    line_q    <= line_d;
    frame_q   <= frame_d;
  end
  assign o_Display_On  = display_q;
  assign o_Line_Start  = line_q;
  assign o_Frame_Start = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of default 640x480 timing and a tiny 8x6 configuration
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_d, en_d, rst_s, en_s;
  logic hs_d, vs_d, disp_d, ls_d, fs_d;
  logic hs_s, vs_s, disp_s, ls_s, fs_s;
  logic [9:0] col_d, row_d;
  logic [3:0] col_s, row_s;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .i_Clk(clk), .i_Rst(rst_d), .i_Pix_En(en_d),
    .o_HSync(hs_d), .o_VSync(vs_d), .o_Display_On(disp_d),
    .o_Col_Count(col_d), .o_Row_Count(row_d),
    .o_Line_Start(ls_d), .o_Frame_Start(fs_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(4)
  ) dut_s (
    .i_Clk(clk), .i_Rst(rst_s), .i_Pix_En(en_s),
    .o_HSync(hs_s), .o_VSync(vs_s), .o_Display_On(disp_s),
    .o_Col_Count(col_s), .o_Row_Count(row_s),
    .o_Line_Start(ls_s), .o_Frame_Start(fs_s)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_d(input string tag, input int col, input int row, input int hs, input int vs,
                       input int disp, input int ls, input int fs);
    chk({tag, "_col"}, col_d, col);
    chk({tag, "_row"}, row_d, row);
    chk({tag, "_hs"}, hs_d, hs);
    chk({tag, "_vs"}, vs_d, vs);
    chk({tag, "_disp"}, disp_d, disp);
    chk({tag, "_ls"}, ls_d, ls);
    chk({tag, "_fs"}, fs_d, fs);
  endtask

  initial begin
    int hs_low, hs_first, hs_last, n_ls, n_fs, n_disp, n_hs, n_vs, hs_mask, vs_mask;
    rst_d = 1'b1; en_d = 1'b0; rst_s = 1'b1; en_s = 1'b0;
    step();
    step();
    chk_d("rst", 799, 524, 1, 1, 0, 0, 0);
    chk("s_rst_col", col_s, 7);
    chk("s_rst_row", row_s, 5);
    chk("s_rst_hs", hs_s, 0);
    chk("s_rst_vs", vs_s, 0);
    chk("s_rst_disp", disp_s, 0);
    rst_d = 1'b0; rst_s = 1'b0;
    en_d = 1'b1;
    step();
    chk_d("first", 0, 0, 1, 1, 1, 1, 1);
    en_d = 1'b0;
    step();
    chk_d("hold", 0, 0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      en_d = (i % 2 == 0);
      step();
    end
    chk("half_col", col_d, 5);
    hs_low = 0; hs_first = -1; hs_last = -1;
    en_d = 1'b1;
    for (int i = 0; i < 793; i++) begin
      step();
      if (hs_d == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = col_d;
        hs_last = col_d;
      end
    end
    chk("hs_low_cnt", hs_low, 96);
    chk("hs_first", hs_first, 656);
    chk("hs_last", hs_last, 751);
    chk_d("c798", 798, 0, 1, 1, 0, 0, 0);
    step();
    chk_d("c799", 799, 0, 1, 1, 0, 0, 0);
    step();
    chk_d("line1", 0, 1, 1, 1, 1, 1, 0);
    en_d = 1'b0;
    step();
    chk_d("line1_hold", 0, 1, 1, 1, 1, 0, 0);
    en_d = 1'b1;
    for (int i = 0; i < 7500; i++) step();
    chk_d("mid", 300, 10, 1, 1, 1, 0, 0);
    rst_d = 1'b1;
    step();
    chk_d("mid_rst", 799, 524, 1, 1, 0, 0, 0);
    rst_d = 1'b0;
    step();
    chk_d("after_rst", 0, 0, 1, 1, 1, 1, 1);
    en_d = 1'b0;
    n_ls = 0; n_fs = 0; n_disp = 0; n_hs = 0; n_vs = 0; hs_mask = 0; vs_mask = 0;
    en_s = 1'b1;
    for (int i = 0; i < 48; i++) begin
      step();
      chk("s_col", col_s, i % 8);
      chk("s_row", row_s, i / 8);
      n_ls += ls_s; n_fs += fs_s; n_disp += disp_s; n_hs += hs_s; n_vs += vs_s;
      if (hs_s) hs_mask |= 1 << col_s;
      if (vs_s) vs_mask |= 1 << row_s;
    end
    chk("s_ls_cnt", n_ls, 6);
    chk("s_fs_cnt", n_fs, 1);
    chk("s_disp_cnt", n_disp, 12);
    chk("s_hs_cnt", n_hs, 12);
    chk("s_hs_cols", hs_mask, 'h60);
    chk("s_vs_cnt", n_vs, 8);
    chk("s_vs_rows", vs_mask, 'h10);
    n_ls = 0; n_fs = 0;
    for (int i = 0; i < 96; i++) begin
      en_s = (i % 2 == 0);
      step();
      n_ls += ls_s; n_fs += fs_s;
      if (i == 0) chk("s_half_fs", fs_s, 1);
      if (i == 1) chk("s_half_fs_width", fs_s, 0);
      if (i == 3) chk("s_half_col", col_s, 1);
    end
    chk("s_half_ls_cnt", n_ls, 6);
    chk("s_half_fs_cnt", n_fs, 1);
    chk("s_half_end_col", col_s, 7);
    chk("s_half_end_row", row_s, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator that replaces the fixed 640x480 sync-pulse counter.
- Adds the following over that counter:
  - Explicit front porch, sync and back porch per axis.
  - Programmable sync polarity.
  - Pixel-clock enable, so a 50 MHz board clock can drive 25 MHz timing.
  - Synchronous reset.
  - Registered line/frame start strobes.
- Sits between the board clock and the pattern/game renderers.
- Its column/row counts index the active picture.

Parameters:
- H_ACTIVE, 640, visible columns
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible rows
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, HSync active level (0 = active-low)
- V_POL, 0, VSync active level (0 = active-low)
- CNT_W, 10, width of the column/row counters

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  synchronous, active-high reset
- i_Pix_En  in  1  pixel tick; timing advances only on cycles where it is 1
- o_HSync  out  1  horizontal sync, level per H_POL
- o_VSync  out  1  vertical sync, level per V_POL
- o_Display_On  out  1  current position is inside the active area
- o_Col_Count  out  CNT_W  current column, 0..H_TOTAL-1
- o_Row_Count  out  CNT_W  current row, 0..V_TOTAL-1
- o_Line_Start  out  1  one-clock strobe when the column becomes 0
- o_Frame_Start  out  1  one-clock strobe when column and row both become 0

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Elaboration check: fail if 2**CNT_W < H_TOTAL or 2**CNT_W < V_TOTAL, or if any porch/sync parameter is 0.
- Reset values (i_Rst=1 at a clock edge, with priority over i_Pix_En):
  - o_Col_Count = H_TOTAL-1, o_Row_Count = V_TOTAL-1.
  - o_HSync = ~H_POL, o_VSync = ~V_POL.
  - o_Display_On = 0, both strobes = 0.
  - This is a self-consistent end-of-frame state, so the first enabled tick lands on (0,0).
- Counter advance on an enabled tick (i_Pix_En=1):
  - col = col+1; when col == H_TOTAL-1, col wraps to 0.
  - On that column wrap, row = row+1; when row == V_TOTAL-1, row wraps to 0.
- Output registration:
  - All outputs are registers, computed from the next count value.
  - Sync, display and strobe outputs therefore align with the count values on the same cycle (zero relative skew, one clock after the tick).
- Sync levels:
  - HSync is active (== H_POL) for col in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; otherwise it is ~H_POL.
  - VSync is active (== V_POL) for row in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; otherwise it is ~V_POL. It therefore changes only coincident with a column wrap.
- o_Display_On = (col < H_ACTIVE) && (row < V_ACTIVE).
- Strobes:
  - o_Line_Start = 1 on the cycle the column becomes 0.
  - o_Frame_Start = 1 on the cycle the column becomes 0 with the row becoming 0.
  - Each strobe lasts exactly one i_Clk cycle, even when i_Pix_En stays low afterwards.
- i_Pix_En = 0: counts, syncs and o_Display_On hold; strobes are 0.
- Reset mid-frame: on the next edge the block returns to the reset state. No partial line is completed, and no strobe is emitted on the reset cycle.

Decomposition:
- Package vga_timing_pkg holds:
  - Default timing constant sets: 640x480@60 (above) and 800x600@60 (40 MHz: 800/40/128/88, 600/1/4/23).
  - A polarity encoding constant.
- One natural sub-module, vga_axis_counter:
  - Parameters ACTIVE/FP/SYNC/BP/POL/W.
  - Inputs: advance enable. Outputs: count, wrap flag, sync level, active flag.
  - Instantiated once per axis; the vertical instance is enabled by the horizontal wrap flag AND i_Pix_En.

Test Plan:
- Reset, then i_Pix_En=1 for 1 clock (defaults) -> col=0, row=0, o_Frame_Start=1, o_Line_Start=1, o_Display_On=1, HSync=1, VSync=1.
- Defaults, run one full frame of 420000 ticks -> exactly 525 Line_Start and 1 Frame_Start.
  - HSync low for cols 656..751 (96 ticks per line).
  - VSync low for rows 490..491.
  - Display_On high for 307200 ticks.
- i_Pix_En toggling 1,0,1,0 (half-rate) -> counts advance every other clock; each strobe is 1 clock wide; the frame takes 840000 clocks.
- Small params (H 4/1/2/1, V 3/1/1/1, H_POL=1, V_POL=1, CNT_W=4) -> col sequence 0..7 wraps.
  - HSync high at cols 5,6.
  - VSync high only on row 4.
  - Display_On high for 12 ticks per frame.
- Assert i_Rst at col=300, row=200 -> next clock col=799, row=524, syncs inactive, Display_On=0; the next enabled tick gives Frame_Start.
- i_Rst and i_Pix_En both 1 on the same edge -> reset wins; no strobe that cycle.
